xbee_tx_frame: RTL
==================

Name: xbee_tx_frame

Overview:
- Builds and streams one XBee API Transmit Request frame (API ID 0x10) byte by byte into the UART transmitter.
- Counterpart of the API 0x90 receive-frame parser: motor, telemetry or ack bytes go back to the remote node in the same framing.
- Sits between the control logic, which supplies the payload and destination, and the uart tx byte interface.

Parameters:
- PAYLOAD_BYTES, 4: RF data bytes per frame, N; legal range 1..16.
- DEST_NET, 16'hFFFE: 16-bit destination network address sent in the frame.
- RADIUS, 8'h00: broadcast radius byte.
- TX_OPTIONS, 8'h00: transmit options byte.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- send  in  1  request a frame; sampled only in IDLE
- frame_id  in  8  frame ID byte; latched on accept
- dest_addr  in  64  64-bit destination address, MSB sent first; latched on accept
- payload  in  8*N  RF data; byte 0 = payload[8N-1 -: 8], sent first; latched on accept
- tx_byte  out  8  byte offered to the UART
- tx_valid  out  1  tx_byte is valid
- tx_ready  in  1  UART accepts tx_byte this cycle
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after the checksum byte is accepted

Behaviour:
- Reset values: tx_byte=0, tx_valid=0, busy=0, done=0; state=IDLE; byte index=0; checksum accumulator=0.
- Reset mid-frame aborts the frame immediately; no partial checksum is sent.
- Frame byte order, index 0..17+N:
  - 7E
  - LEN_HI, LEN_LO, where LEN = 14+N
  - 10
  - frame_id
  - dest_addr, 8 bytes
  - DEST_NET hi, DEST_NET lo
  - RADIUS
  - TX_OPTIONS
  - payload, N bytes
  - CHK
- Checksum:
  - 8-bit accumulator, cleared on accept.
  - Adds each byte of index 3..16+N when that byte's handshake completes; the add wraps mod 256.
  - CHK = 8'hFF - accumulator.
- States: IDLE, SEND, ESC2 (escape feature only), FINISH.
- IDLE:
  - busy=0.
  - send=1 latches the inputs, clears the index and sets busy=1 in the next cycle.
  - Also next cycle: tx_valid=1 with tx_byte=7E; state=SEND.
  - Accept-to-first-valid latency is 1 cycle.
- SEND:
  - tx_valid held 1.
  - tx_byte is driven from the index mux and must stay stable while tx_ready=0.
  - On tx_valid && tx_ready: index increments and the next byte appears the following cycle.
  - Maximum throughput is one byte per cycle.
  - When the handshake completes on index 17+N: next cycle state=FINISH, tx_valid=0.
- FINISH:
  - done=1 for exactly one cycle, busy=0.
  - Returns to IDLE next cycle.
- send while busy=1 or in FINISH is ignored; no queuing.
- send in IDLE during the cycle after done is accepted normally.
- Changes on frame_id, dest_addr or payload after accept do not affect the frame in flight.
- tx_ready asserted while tx_valid=0 has no effect.

Optional Feature:
- Macro: XBEE_TX_ESCAPE_EN.
- Defined (API mode 2):
  - Any byte at index ≥1 equal to 7E, 7D, 11 or 13 is sent as 7D, then (byte XOR 20).
  - This includes length and CHK.
  - SEND emits 7D; after its handshake the block goes to ESC2 and emits the XORed byte; after that handshake the index advances.
  - The checksum is computed over unescaped values.
  - Index 0 (7E) is never escaped.
- Undefined:
  - No ESC2 state; all bytes are sent raw.
  - Frame length is always 18+N bytes.

Decomposition:
- Package xbee_pkg holds:
  - START_DELIM=8'h7E
  - API_TX_REQ=8'h10
  - API_RX_PKT=8'h90
  - ESC_CHAR=8'h7D
  - ESC_XOR=8'h20
  - XON=8'h11
  - XOFF=8'h13
  - TX_HDR_LEN=14
  - a state enum typedef
- The package is shared with the receive-frame parser.
- One sub-module is natural: xbee_byte_stuffer. It provides the escape decision and XOR, and is instantiated only under XBEE_TX_ESCAPE_EN.

Test Plan:
1. Basic frame, escape off, tx_ready tied 1, N=4:
   - Stimulus: frame_id=01, dest_addr=0013A20040A1B2C3, payload=01020304, send pulse.
   - Required stream (22 bytes): 7E 00 12 10 01 00 13 A2 00 40 A1 B2 C3 FF FE 00 00 01 02 03 04 DC.
   - done pulses one cycle after DC is accepted.
2. Backpressure, same frame:
   - Stimulus: tx_ready low 5 cycles at index 9.
   - Required: tx_byte stays 40 with tx_valid=1 throughout; stream identical to test 1.
3. Escape on:
   - Stimulus: dest_addr=0, frame_id=01, payload=7E000000.
   - Required stream (23 bytes): 7E 00 12 10 01 00×8 FF FE 00 00 7D 5E 00 00 00 73.
   - Same stimulus with escape off: 22 bytes, raw 7E in the data field, CHK=73.
4. send ignored while busy:
   - Stimulus: second send at index 5.
   - Required: only one frame emitted, one done pulse.
   - A send in the cycle after done starts a new frame with 7E one cycle later.
5. Reset mid-frame:
   - Stimulus: reset at index 12.
   - Required: next cycle tx_valid=0, busy=0, done=0.
   - A following send produces a complete, correct frame (checksum not polluted).
6. Input stability:
   - Stimulus: change payload to FFFFFFFF one cycle after accept.
   - Required: emitted data is still 01020304 with CHK=DC.

Source files
------------

// File: rtl/xbee_pkg.sv
// rtl/xbee_pkg.sv - XBee API framing constants and state type
// Shared by the transmit-frame builder and the API 0x90 receive-frame parser.
package xbee_pkg;

  localparam logic [7:0] START_DELIM = 8'h7E;
  localparam logic [7:0] API_TX_REQ  = 8'h10;
  localparam logic [7:0] API_RX_PKT  = 8'h90;
  localparam logic [7:0] ESC_CHAR    = 8'h7D;
  localparam logic [7:0] ESC_XOR     = 8'h20;
  localparam logic [7:0] XON         = 8'h11;
  localparam logic [7:0] XOFF        = 8'h13;
  localparam int         TX_HDR_LEN  = 14;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    ESC2,
    FINISH
  } tx_state_t;

endpackage

// File: rtl/xbee_byte_stuffer.sv
// rtl/xbee_byte_stuffer.sv - API mode 2 escape decision and XOR for one byte
// Used by xbee_tx_frame only when XBEE_TX_ESCAPE_EN is defined.
module xbee_byte_stuffer
  import xbee_pkg::*;
(
  input  logic [7:0] data,
  output logic       escape,
  output logic [7:0] stuffed
);

  assign escape  = (data == START_DELIM) || (data == ESC_CHAR) ||
                   (data == XON) || (data == XOFF);
  assign stuffed = data ^ ESC_XOR;

endmodule

// File: rtl/xbee_tx_frame.sv
// rtl/xbee_tx_frame.sv - XBee API 0x10 Transmit Request frame builder/streamer
// Optional macro XBEE_TX_ESCAPE_EN enables API mode 2 byte escaping.
module xbee_tx_frame
  import xbee_pkg::*;
#(
  parameter int          PAYLOAD_BYTES = 4,
  parameter logic [15:0] DEST_NET      = 16'hFFFE,
  parameter logic [7:0]  RADIUS        = 8'h00,
  parameter logic [7:0]  TX_OPTIONS    = 8'h00
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       send,
  input  logic [7:0]                 frame_id,
  input  logic [63:0]                dest_addr,
  input  logic [8*PAYLOAD_BYTES-1:0] payload,
  output logic [7:0]                 tx_byte,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic                       busy,
  output logic                       done
);

  localparam logic [15:0] FRAME_LEN = 16'(TX_HDR_LEN + PAYLOAD_BYTES);
  localparam logic [5:0]  PAY_IDX   = 6'd17;
  localparam logic [5:0]  LAST_IDX  = 6'(17 + PAYLOAD_BYTES);

  tx_state_t                  state;
  logic [5:0]                 idx, nidx;
  logic [7:0]                 acc, acc_sum, cur_raw, next_raw, fid_q;
  logic [7:0]                 dest_byte, pay_byte;
  logic [63:0]                dest_q;
  logic [8*PAYLOAD_BYTES-1:0] pl_q;
  logic [2:0]                 di;
  logic [3:0]                 pi;
  logic                       next_esc;

`ifdef XBEE_TX_ESCAPE_EN
  logic       cur_esc;
  logic [7:0] cur_xor, next_xor;

  xbee_byte_stuffer u_stuffer (
    .data    (next_raw),
    .escape  (next_esc),
    .stuffed (next_xor)
  );
`else
  assign next_esc = 1'b0;
`endif

  // Next byte is built from the latched fields and the checksum including the current byte.
  always_comb begin
    nidx      = idx + 6'd1;
    di        = 3'(nidx - 6'd5);
    pi        = 4'(nidx - PAY_IDX);
    acc_sum   = (idx >= 6'd3 && idx < LAST_IDX) ? acc + cur_raw : acc;
    dest_byte = 8'h00;
    for (int b = 0; b < 8; b++)
      if (di == 3'(b)) dest_byte = dest_q[8*(7-b) +: 8];
    pay_byte = 8'h00;
    for (int b = 0; b < PAYLOAD_BYTES; b++)
      if (pi == 4'(b)) pay_byte = pl_q[8*(PAYLOAD_BYTES-1-b) +: 8];
    if (nidx == 6'd1)           next_raw = FRAME_LEN[15:8];
    else if (nidx == 6'd2)      next_raw = FRAME_LEN[7:0];
    else if (nidx == 6'd3)      next_raw = API_TX_REQ;
    else if (nidx == 6'd4)      next_raw = fid_q;
    else if (nidx < 6'd13)      next_raw = dest_byte;
    else if (nidx == 6'd13)     next_raw = DEST_NET[15:8];
    else if (nidx == 6'd14)     next_raw = DEST_NET[7:0];
    else if (nidx == 6'd15)     next_raw = RADIUS;
    else if (nidx == 6'd16)     next_raw = TX_OPTIONS;
    else if (nidx < LAST_IDX)   next_raw = pay_byte;
    else                        next_raw = 8'hFF - acc_sum;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      acc      <= '0;
      cur_raw  <= '0;
      fid_q    <= '0;
      dest_q   <= '0;
      pl_q     <= '0;
      tx_byte  <= '0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef XBEE_TX_ESCAPE_EN
      cur_esc  <= 1'b0;
      cur_xor  <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (send) begin
          fid_q    <= frame_id;
          dest_q   <= dest_addr;
          pl_q     <= payload;
          idx      <= '0;
          acc      <= '0;
          cur_raw  <= START_DELIM;
          tx_byte  <= START_DELIM;
          tx_valid <= 1'b1;
          busy     <= 1'b1;
          state    <= SEND;
`ifdef XBEE_TX_ESCAPE_EN
          cur_esc  <= 1'b0;
`endif
        end
        SEND, ESC2: if (tx_ready) begin
`ifdef XBEE_TX_ESCAPE_EN
          if (state == SEND && cur_esc) begin
            tx_byte <= cur_xor;
            state   <= ESC2;
          end else
`endif
          if (idx == LAST_IDX) begin
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= FINISH;
          end else begin
            idx     <= nidx;
            acc     <= acc_sum;
            cur_raw <= next_raw;
            tx_byte <= next_esc ? ESC_CHAR : next_raw;
            state   <= SEND;
`ifdef XBEE_TX_ESCAPE_EN
            cur_esc <= next_esc;
            cur_xor <= next_xor;
`endif
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
